// File: rtl/game_collision_if.sv
// Pixel-stream bundle between the object drawers and the collision tracker.
// master drives the pixel stream and reads results; slave is the tracker.
interface game_collision_if #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned COORD_W = 11
);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                startOfFrame;
  logic                drawing_request_kong;
  logic [N_CH-1:0]     drawing_request;
  logic [N_CH-1:0]     channel_enable;
  logic [COORD_W-1:0]  pixelX;
  logic [COORD_W-1:0]  pixelY;
  logic [N_CH-1:0]     collision;
  logic [N_CH-1:0]     SingleHitPulse;
  logic                any_hit;
  logic                first_hit_valid;
  logic [IDX_W-1:0]    first_hit_idx;
  logic [COORD_W-1:0]  first_hit_x;
  logic [COORD_W-1:0]  first_hit_y;
  logic [N_CH-1:0]     frame_hit_mask;

  modport master (
    output startOfFrame, drawing_request_kong, drawing_request, channel_enable,
           pixelX, pixelY,
    input  collision, SingleHitPulse, any_hit, first_hit_valid, first_hit_idx,
           first_hit_x, first_hit_y, frame_hit_mask
  );

  modport slave (
    input  startOfFrame, drawing_request_kong, drawing_request, channel_enable,
           pixelX, pixelY,
    output collision, SingleHitPulse, any_hit, first_hit_valid, first_hit_idx,
           first_hit_x, first_hit_y, frame_hit_mask
  );
endinterface

// File: rtl/game_collision_tracker.sv
// Per-frame kong-vs-object collision tracker: thresholded one-shot hit pulses,
// first-hit capture and a per-frame hit summary published at start of frame.
module game_collision_tracker #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned MIN_PIXELS = 1,
  parameter int unsigned COORD_W    = 11
) (
  input  logic             clk,
  input  logic             resetN,
  game_collision_if.slave  bus
);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned THR   = (MIN_PIXELS == 0) ? 1 : MIN_PIXELS;
  localparam logic [CNT_W:0]   THR_W   = CW1'(THR);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [N_CH];
  logic [N_CH-1:0]    flag;
  logic [N_CH-1:0]    coll;
  logic [N_CH-1:0]    qual;
  logic [IDX_W-1:0]   qual_idx;
  logic               fhv_base;

  logic [N_CH-1:0]    pulse_q;
  logic               any_q;
  logic               fhv_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [N_CH-1:0]    mask_q;

  assign coll = {N_CH{bus.drawing_request_kong}} & bus.drawing_request & bus.channel_enable;

  // On startOfFrame a channel is judged as if its count and flag were already cleared.
  always_comb begin
    qual     = '0;
    qual_idx = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      qual[i] = coll[i] & (bus.startOfFrame | ~flag[i]) &
                ((bus.startOfFrame ? CW1'(1) : ({1'b0, cnt[i]} + CW1'(1))) >= THR_W);
    end
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (qual[i]) qual_idx = IDX_W'(i);
    end
  end

  assign fhv_base = bus.startOfFrame ? 1'b0 : fhv_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(N_CH); i++) cnt[i] <= '0;
      flag    <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      fhv_q   <= 1'b0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mask_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (bus.startOfFrame)
          cnt[i] <= coll[i] ? CNT_W'(1) : '0;
        else if (coll[i] && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
      flag    <= (bus.startOfFrame ? '0 : flag) | qual;
      pulse_q <= qual;
      any_q   <= |qual;
      if (bus.startOfFrame) mask_q <= flag;
      fhv_q   <= fhv_base | (|qual);
      if ((|qual) && !fhv_base) begin
        idx_q <= qual_idx;
        x_q   <= bus.pixelX;
        y_q   <= bus.pixelY;
      end
    end
  end

  assign bus.collision       = coll;
  assign bus.SingleHitPulse  = pulse_q;
  assign bus.any_hit         = any_q;
  assign bus.first_hit_valid = fhv_q;
  assign bus.first_hit_idx   = idx_q;
  assign bus.first_hit_x     = x_q;
  assign bus.first_hit_y     = y_q;
  assign bus.frame_hit_mask  = mask_q;
endmodule
